// File: rtl/mapram_lookup_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mapram_lookup_sched
//  Description : Queues incoming event codes, issues one mapping-RAM read per
//                cycle, aligns the returned word with its code and owns the
//                active-bank select with drain-before-swap sequencing.
//  Revision    : 1.0  initial release
// ============================================================================
module mapram_lookup_sched #(
   parameter int FIFO_DEPTH = 8,
   parameter int RD_LAT     = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  evt_code,
   input  logic        evt_valid,
   input  logic        map_en,
   input  logic        clear_busy,
   input  logic        swap_req,
   input  logic [15:0] ram_data,
   output logic [7:0]  rd_addr,
   output logic        rd_en,
   output logic        rd_sel,
   output logic [7:0]  map_code,
   output logic [15:0] map_data,
   output logic        map_valid,
   output logic        swap_ack,
   output logic        fifo_ovf,
   input  logic        ovf_clr,
   output logic        busy
);

   localparam int            c_AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_SWAP  = 2'd2
   } state_t;

   // Event FIFO
   logic [7:0]              r_fifo [FIFO_DEPTH];
   logic [c_AW-1:0]         r_wr_ptr;
   logic [c_AW-1:0]         r_rd_ptr;
   logic [c_AW:0]           r_count;

   // In-flight pipeline, one stage per cycle of RAM latency
   logic [RD_LAT-1:0]       r_pv;
   logic [RD_LAT-1:0][7:0]  r_pc;
   logic [RD_LAT-1:0]       w_pv_in;
   logic [RD_LAT-1:0][7:0]  w_pc_in;

   // Control and output registers
   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_swap_pend;
   logic                    r_rd_sel;
   logic                    r_swap_ack;
   logic                    r_ovf;
   logic [7:0]              r_rd_addr;
   logic                    r_map_valid;
   logic [7:0]              r_map_code;
   logic [15:0]             r_map_data;

   logic                    w_push_req;
   logic                    w_push;
   logic                    w_issue;
   logic                    w_run_ok;
   logic                    w_toggle;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_inflight;
   logic                    w_ovf_set;
   logic                    w_result;
   logic [7:0]              w_head;

   assign w_full     = (r_count == c_FULL);
   assign w_empty    = (r_count == '0);
   assign w_inflight = |r_pv;
   assign w_head     = r_fifo[r_rd_ptr];

   // Code 0x00 means "no event" and is never queued
   assign w_push_req = evt_valid && (evt_code != 8'h00) && map_en;
   assign w_issue    = w_run_ok && !w_empty && !clear_busy && map_en;
   // A push into a full FIFO still fits when the head leaves the same cycle
   assign w_push     = w_push_req && (!w_full || w_issue);
   assign w_ovf_set  = w_push_req && w_full && !w_issue;
   assign w_result   = r_pv[RD_LAT-1] && map_en;

   // Bank sequencer: stop issuing on a pending swap, wait for the pipeline to
   // empty, then flip the bank so no lookup straddles two banks
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and issue permission
   always_comb begin
      w_state_nxt = r_state;
      w_run_ok    = 1'b0;
      w_toggle    = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (r_swap_pend) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_run_ok = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!w_inflight) begin
               w_state_nxt = ST_SWAP;
            end
         end
         ST_SWAP: begin
            w_toggle    = 1'b1;
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // FIFO storage; stale entries are harmless because pointers gate access
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= evt_code;
      end
   end

   // FIFO pointers and occupancy; disabling mapping empties the queue
   always_ff @(posedge clk_i) begin
      if (rst_i || !map_en) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         case ({w_push, w_issue})
            2'b10:   r_count <= r_count + (c_AW + 1)'(1);
            2'b01:   r_count <= r_count - (c_AW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Shift-register inputs: stage 0 takes the new issue, later stages shift
   generate
      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign w_pv_in[gi] = w_issue;
            assign w_pc_in[gi] = w_head;
         end else begin : g_shift
            assign w_pv_in[gi] = r_pv[gi-1];
            assign w_pc_in[gi] = r_pc[gi-1];
         end
      end
   endgenerate

   // In-flight tracking; dropping map_en kills outstanding lookups
   always_ff @(posedge clk_i) begin
      if (rst_i || !map_en) begin
         r_pv <= '0;
         r_pc <= '0;
      end else begin
         r_pv <= w_pv_in;
         r_pc <= w_pc_in;
      end
   end

   // Result register: capture RAM data when the matching code reaches the end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_map_valid <= 1'b0;
         r_map_code  <= 8'h00;
         r_map_data  <= 16'h0000;
      end else begin
         r_map_valid <= w_result;
         if (w_result) begin
            r_map_code <= r_pc[RD_LAT-1];
            r_map_data <= ram_data;
         end
      end
   end

   // Read address holds its last issued value between issues
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_addr <= 8'h00;
      end else if (w_issue) begin
         r_rd_addr <= w_head;
      end
   end

   // Bank select, acknowledge pulse and pending-swap latch; requests seen in
   // the SWAP cycle merge into the swap being performed
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_sel    <= 1'b0;
         r_swap_ack  <= 1'b0;
         r_swap_pend <= 1'b0;
      end else begin
         r_swap_ack <= w_toggle;
         if (w_toggle) begin
            r_rd_sel    <= ~r_rd_sel;
            r_swap_pend <= 1'b0;
         end else begin
            r_swap_pend <= r_swap_pend | swap_req;
         end
      end
   end

   // Sticky overflow flag; a new overflow beats a simultaneous clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign rd_en     = w_issue;
   assign rd_addr   = w_issue ? w_head : r_rd_addr;
   assign rd_sel    = r_rd_sel;
   assign map_valid = r_map_valid;
   assign map_code  = r_map_code;
   assign map_data  = r_map_data;
   assign swap_ack  = r_swap_ack;
   assign fifo_ovf  = r_ovf;
   assign busy      = !w_empty || w_inflight || r_swap_pend;

endmodule
`default_nettype wire

// File: tb/tb_mapram_lookup_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mapram_lookup_sched
//  Description : Directed self-checking bench for mapram_lookup_sched with a
//                two-bank RAM environment (RD_LAT = 1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mapram_lookup_sched;

   logic        clk_i      = 1'b0;
   logic        rst_i      = 1'b1;
   logic [7:0]  evt_code   = 8'h00;
   logic        evt_valid  = 1'b0;
   logic        map_en     = 1'b0;
   logic        clear_busy = 1'b0;
   logic        swap_req   = 1'b0;
   logic [15:0] ram_data   = 16'h0000;
   logic        ovf_clr    = 1'b0;
   logic [7:0]  rd_addr;
   logic        rd_en;
   logic        rd_sel;
   logic [7:0]  map_code;
   logic [15:0] map_data;
   logic        map_valid;
   logic        swap_ack;
   logic        fifo_ovf;
   logic        busy;

   mapram_lookup_sched #(.FIFO_DEPTH(8), .RD_LAT(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .evt_code(evt_code), .evt_valid(evt_valid),
      .map_en(map_en), .clear_busy(clear_busy), .swap_req(swap_req),
      .ram_data(ram_data), .rd_addr(rd_addr), .rd_en(rd_en), .rd_sel(rd_sel),
      .map_code(map_code), .map_data(map_data), .map_valid(map_valid),
      .swap_ack(swap_ack), .fifo_ovf(fifo_ovf), .ovf_clr(ovf_clr), .busy(busy)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] cyc;
      logic [7:0]  code;
      logic [15:0] data;
   } res_t;

   res_t        res_q[$];
   logic [15:0] ram1 [256];
   logic [15:0] ram2 [256];
   int          cyc       = 0;
   int          rd_en_cnt = 0;
   int          ack_cnt   = 0;
   int          ack_cyc   = 0;
   int          n_checks  = 0;
   int          n_pass    = 0;

   // Two-bank synchronous RAM, one cycle read latency
   always @(posedge clk_i) begin
      if (rd_en) ram_data <= rd_sel ? ram2[rd_addr] : ram1[rd_addr];
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   // Record results and strobes mid-cycle
   always @(negedge clk_i) begin
      if (map_valid) res_q.push_back('{cyc: 32'(cyc), code: map_code, data: map_data});
      if (rd_en) rd_en_cnt++;
      if (swap_ack) begin
         ack_cnt++;
         ack_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr_mon();
      res_q.delete();
      rd_en_cnt = 0;
      ack_cnt   = 0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) tick();
      @(negedge clk_i);
      n_checks++; if (map_valid !== 1'b0) $display("FAIL reset_map_valid: got %b want 0", map_valid); else n_pass++;
      n_checks++; if (map_code !== 8'h00) $display("FAIL reset_map_code: got %h want 00", map_code); else n_pass++;
      n_checks++; if (map_data !== 16'h0000) $display("FAIL reset_map_data: got %h want 0000", map_data); else n_pass++;
      n_checks++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rd_en); else n_pass++;
      n_checks++; if (rd_addr !== 8'h00) $display("FAIL reset_rd_addr: got %h want 00", rd_addr); else n_pass++;
      n_checks++; if (rd_sel !== 1'b0) $display("FAIL reset_rd_sel: got %b want 0", rd_sel); else n_pass++;
      n_checks++; if (swap_ack !== 1'b0) $display("FAIL reset_swap_ack: got %b want 0", swap_ack); else n_pass++;
      n_checks++; if (fifo_ovf !== 1'b0) $display("FAIL reset_fifo_ovf: got %b want 0", fifo_ovf); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      tick();
      rst_i = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0]  ec [3];
      logic [15:0] ed [3];
      int p;
      ec = '{8'h12, 8'h34, 8'h56};
      ed = '{16'hA001, 16'hA002, 16'hA003};
      map_en = 1'b1;
      tick();
      clr_mon();
      p = cyc;
      for (int i = 0; i < 3; i++) begin
         evt_valid = 1'b1;
         evt_code  = ec[i];
         tick();
      end
      evt_valid = 1'b0;
      repeat (6) tick();
      @(negedge clk_i);
      n_checks++; if (res_q.size() !== 3) $display("FAIL basic_count: got %0d want 3", res_q.size()); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         if (i < res_q.size()) begin
            n_checks++; if (res_q[i].code !== ec[i]) $display("FAIL basic_code%0d: got %h want %h", i, res_q[i].code, ec[i]); else n_pass++;
            n_checks++; if (res_q[i].data !== ed[i]) $display("FAIL basic_data%0d: got %h want %h", i, res_q[i].data, ed[i]); else n_pass++;
            n_checks++; if (res_q[i].cyc !== 32'(p + 3 + i)) $display("FAIL basic_cycle%0d: got %0d want %0d", i, res_q[i].cyc, p + 3 + i); else n_pass++;
         end
      end
      n_checks++; if (rd_en_cnt !== 3) $display("FAIL basic_rd_en_count: got %0d want 3", rd_en_cnt); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_idle: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_zero_code();
      tick();
      clr_mon();
      evt_valid = 1'b1;
      evt_code  = 8'h00;
      tick();
      evt_valid = 1'b0;
      @(negedge clk_i);
      n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else n_pass++;
      repeat (3) tick();
      @(negedge clk_i);
      n_checks++; if (rd_en_cnt !== 0) $display("FAIL zero_rd_en_count: got %0d want 0", rd_en_cnt); else n_pass++;
      n_checks++; if (res_q.size() !== 0) $display("FAIL zero_results: got %0d want 0", res_q.size()); else n_pass++;
   endtask

   task automatic test_overflow();
      int o;
      tick();
      clr_mon();
      clear_busy = 1'b1;
      o = cyc;
      for (int i = 1; i <= 9; i++) begin
         evt_valid = 1'b1;
         evt_code  = 8'(i);
         tick();
      end
      // Full FIFO: overflow push coincides with a clear request
      evt_code = 8'h0A;
      ovf_clr  = 1'b1;
      @(negedge clk_i);
      n_checks++; if (fifo_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", fifo_ovf); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL ovf_busy: got %b want 1", busy); else n_pass++;
      n_checks++; if (rd_en_cnt !== 0) $display("FAIL ovf_stall_rd_en: got %0d want 0", rd_en_cnt); else n_pass++;
      tick();
      ovf_clr    = 1'b0;
      evt_valid  = 1'b0;
      clear_busy = 1'b0;
      @(negedge clk_i);
      n_checks++; if (fifo_ovf !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", fifo_ovf); else n_pass++;
      repeat (14) tick();
      @(negedge clk_i);
      n_checks++; if (res_q.size() !== 8) $display("FAIL ovf_count: got %0d want 8", res_q.size()); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         if (i < res_q.size()) begin
            n_checks++; if (res_q[i].code !== 8'(i + 1)) $display("FAIL ovf_code%0d: got %h want %h", i, res_q[i].code, 8'(i + 1)); else n_pass++;
            n_checks++; if (res_q[i].data !== (16'h1000 | 16'(i + 1))) $display("FAIL ovf_data%0d: got %h want %h", i, res_q[i].data, 16'h1000 | 16'(i + 1)); else n_pass++;
            n_checks++; if (res_q[i].cyc !== 32'(o + 12 + i)) $display("FAIL ovf_cycle%0d: got %0d want %0d", i, res_q[i].cyc, o + 12 + i); else n_pass++;
         end
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      @(negedge clk_i);
      n_checks++; if (fifo_ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", fifo_ovf); else n_pass++;
   endtask

   task automatic test_full_pop();
      tick();
      clr_mon();
      clear_busy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         evt_valid = 1'b1;
         evt_code  = 8'h21 + 8'(i);
         tick();
      end
      clear_busy = 1'b0;
      evt_code   = 8'h29;
      @(negedge clk_i);
      n_checks++; if (rd_en !== 1'b1) $display("FAIL fullpop_rd_en: got %b want 1", rd_en); else n_pass++;
      n_checks++; if (rd_addr !== 8'h21) $display("FAIL fullpop_rd_addr: got %h want 21", rd_addr); else n_pass++;
      tick();
      evt_valid = 1'b0;
      repeat (14) tick();
      @(negedge clk_i);
      n_checks++; if (fifo_ovf !== 1'b0) $display("FAIL fullpop_no_ovf: got %b want 0", fifo_ovf); else n_pass++;
      n_checks++; if (res_q.size() !== 9) $display("FAIL fullpop_count: got %0d want 9", res_q.size()); else n_pass++;
      for (int i = 0; i < 9; i++) begin
         if (i < res_q.size()) begin
            n_checks++; if (res_q[i].code !== 8'h21 + 8'(i)) $display("FAIL fullpop_code%0d: got %h want %h", i, res_q[i].code, 8'h21 + 8'(i)); else n_pass++;
            n_checks++; if (res_q[i].data !== 16'h1021 + 16'(i)) $display("FAIL fullpop_data%0d: got %h want %h", i, res_q[i].data, 16'h1021 + 16'(i)); else n_pass++;
         end
      end
   endtask

   task automatic test_swap();
      int p;
      tick();
      clr_mon();
      p = cyc;
      for (int i = 0; i < 4; i++) begin
         evt_valid = 1'b1;
         evt_code  = 8'h41 + 8'(i);
         swap_req  = (i == 1);
         tick();
      end
      evt_valid = 1'b0;
      swap_req  = 1'b0;
      repeat (10) tick();
      @(negedge clk_i);
      n_checks++; if (ack_cnt !== 1) $display("FAIL swap_ack_count: got %0d want 1", ack_cnt); else n_pass++;
      n_checks++; if (ack_cyc !== p + 5) $display("FAIL swap_ack_cycle: got %0d want %0d", ack_cyc, p + 5); else n_pass++;
      n_checks++; if (rd_sel !== 1'b1) $display("FAIL swap_rd_sel: got %b want 1", rd_sel); else n_pass++;
      n_checks++; if (res_q.size() !== 4) $display("FAIL swap_count: got %0d want 4", res_q.size()); else n_pass++;
      if (res_q.size() > 0) begin
         n_checks++; if (res_q[0].data !== 16'h1041) $display("FAIL swap_old_bank_data: got %h want 1041", res_q[0].data); else n_pass++;
         n_checks++; if (res_q[0].cyc !== 32'(p + 3)) $display("FAIL swap_old_bank_cycle: got %0d want %0d", res_q[0].cyc, p + 3); else n_pass++;
      end
      for (int i = 1; i < 4; i++) begin
         if (i < res_q.size()) begin
            n_checks++; if (res_q[i].code !== 8'h41 + 8'(i)) $display("FAIL swap_code%0d: got %h want %h", i, res_q[i].code, 8'h41 + 8'(i)); else n_pass++;
            n_checks++; if (res_q[i].data !== 16'h2041 + 16'(i)) $display("FAIL swap_new_bank_data%0d: got %h want %h", i, res_q[i].data, 16'h2041 + 16'(i)); else n_pass++;
            n_checks++; if (res_q[i].cyc !== 32'(p + 6 + i)) $display("FAIL swap_cycle%0d: got %0d want %0d", i, res_q[i].cyc, p + 6 + i); else n_pass++;
         end
      end
   endtask

   task automatic test_map_en_drop();
      tick();
      clr_mon();
      clear_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         evt_valid = 1'b1;
         evt_code  = 8'h51 + 8'(i);
         tick();
      end
      evt_valid  = 1'b0;
      clear_busy = 1'b0;
      @(negedge clk_i);
      n_checks++; if (rd_en !== 1'b1) $display("FAIL drop_first_issue: got %b want 1", rd_en); else n_pass++;
      tick();
      map_en = 1'b0;
      @(negedge clk_i);
      n_checks++; if (rd_en !== 1'b0) $display("FAIL drop_no_issue: got %b want 0", rd_en); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL drop_busy_before: got %b want 1", busy); else n_pass++;
      tick();
      evt_valid = 1'b1;
      evt_code  = 8'h55;
      tick();
      evt_valid = 1'b0;
      @(negedge clk_i);
      n_checks++; if (busy !== 1'b0) $display("FAIL drop_busy_after: got %b want 0", busy); else n_pass++;
      map_en = 1'b1;
      repeat (6) tick();
      @(negedge clk_i);
      n_checks++; if (res_q.size() !== 0) $display("FAIL drop_results: got %0d want 0", res_q.size()); else n_pass++;
      n_checks++; if (rd_en_cnt !== 1) $display("FAIL drop_rd_en_count: got %0d want 1", rd_en_cnt); else n_pass++;
      n_checks++; if (rd_sel !== 1'b1) $display("FAIL drop_rd_sel: got %b want 1", rd_sel); else n_pass++;
   endtask

   task automatic test_reset_mid();
      tick();
      clr_mon();
      for (int i = 0; i < 3; i++) begin
         evt_valid = 1'b1;
         evt_code  = 8'h61 + 8'(i);
         rst_i     = (i == 2);
         tick();
      end
      rst_i     = 1'b0;
      evt_valid = 1'b0;
      @(negedge clk_i);
      n_checks++; if (map_valid !== 1'b0) $display("FAIL rstmid_map_valid: got %b want 0", map_valid); else n_pass++;
      n_checks++; if (map_code !== 8'h00) $display("FAIL rstmid_map_code: got %h want 00", map_code); else n_pass++;
      n_checks++; if (map_data !== 16'h0000) $display("FAIL rstmid_map_data: got %h want 0000", map_data); else n_pass++;
      n_checks++; if (rd_en !== 1'b0) $display("FAIL rstmid_rd_en: got %b want 0", rd_en); else n_pass++;
      n_checks++; if (rd_addr !== 8'h00) $display("FAIL rstmid_rd_addr: got %h want 00", rd_addr); else n_pass++;
      n_checks++; if (rd_sel !== 1'b0) $display("FAIL rstmid_rd_sel: got %b want 0", rd_sel); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
      repeat (5) tick();
      @(negedge clk_i);
      n_checks++; if (res_q.size() !== 0) $display("FAIL rstmid_results: got %0d want 0", res_q.size()); else n_pass++;
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         ram1[a] = 16'h1000 | 16'(a);
         ram2[a] = 16'h2000 | 16'(a);
      end
      ram1[8'h12] = 16'hA001;
      ram1[8'h34] = 16'hA002;
      ram1[8'h56] = 16'hA003;
      test_reset();
      test_basic();
      test_zero_code();
      test_overflow();
      test_full_pop();
      test_swap();
      test_map_en_drop();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
